layer0_input_quantizer: RTL and testbench
=========================================

# layer0_input_quantizer

Streaming front end for the readout classifier network. Accepts one frame of signed feature samples serially over a valid/ready stream and quantizes each sample to QBITS unsigned bits. It packs the quantized frame into the flat vector that drives the layer-0 neuron LUTs and holds that vector with a valid/ready handshake until the network input register takes it. It also polices frame framing, drops malformed frames and counts them.

## Interface
- FEAT_W, 16: signed input sample width.
- N_FEAT, 16: features per frame; must be ≥ 2.
- QBITS, 2: quantized bits per feature.
- OFFSET, 0: signed FEAT_W-bit value subtracted before quantization.
- SHIFT, 12: arithmetic right shift applied after the offset.
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-high.
- in_valid, input, 1: sample valid.
- in_ready, output, 1: sample accepted when in_valid && in_ready.
- in_data, input, FEAT_W: signed sample (two's complement).
- in_last, input, 1: marks the final sample of a frame.
- out_valid, output, 1: packed frame available.
- out_ready, input, 1: downstream takes the frame when out_valid && out_ready.
- out_data, output, N_FEAT*QBITS: packed layer-0 input vector.
- err, output, 1: one-cycle pulse per dropped frame.
- err_cnt, output, 16: saturating count of dropped frames.

## Operation
- Quantization, per accepted beat:
  - d = in_data − OFFSET, computed signed at FEAT_W+1 bits.
  - s = d >>> SHIFT.
  - q = 0 if s < 0; q = 2^QBITS−1 if s > 2^QBITS−1; otherwise q = s[QBITS−1:0].
- Packing:
  - The k-th accepted beat of a frame (k = 0..N_FEAT−1) writes q into a shadow register at bits [k*QBITS +: QBITS]. Feature 0 occupies the LSBs.
  - out_data updates only on frame completion; the shadow register is never exposed.
- State machine with states COLLECT, HOLD, DRAIN, and a beat counter cnt in 0..N_FEAT−1:
  - COLLECT: in_ready = 1.
    - Beat with cnt < N_FEAT−1 and in_last = 0: store q, cnt++.
    - Beat with cnt < N_FEAT−1 and in_last = 1 (short frame): discard the frame, pulse err, cnt = 0, stay in COLLECT.
    - Beat with cnt = N_FEAT−1 and in_last = 1: copy shadow plus this q into out_data, out_valid = 1, cnt = 0, go to HOLD.
    - Beat with cnt = N_FEAT−1 and in_last = 0 (long frame): discard the frame, pulse err, cnt = 0, go to DRAIN.
  - HOLD: in_ready = 0. out_data and out_valid stay stable until out_ready. On handshake, out_valid = 0 next cycle and the state returns to COLLECT.
  - DRAIN: in_ready = 1. Accepted beats are discarded with no store and no err. The beat carrying in_last = 1 returns the state to COLLECT with cnt = 0.
- Error counting: err_cnt increments on every err pulse and saturates at 0xFFFF.
- out_data keeps its last value after a handshake; it is not cleared.
- Reset, asynchronous and immediate:
  - state = COLLECT, cnt = 0, out_valid = 0, out_data = 0, shadow = 0, err = 0, err_cnt = 0.
  - in_ready is forced to 0 while rst is high and reads 1 in the first cycle after release.
  - Reset mid-frame or in HOLD discards all partial or pending data; no err is raised.

## Timing
- in_ready is combinational from state and rst only; it never depends on in_valid or out_ready.
- Latency: the final beat accepted at edge t gives out_valid = 1 and valid out_data after edge t.
- Error timing: err is high for exactly the cycle after the offending beat's edge. err_cnt updates on that same edge.
- HOLD lasts at least one cycle, so peak throughput is one frame per N_FEAT+1 cycles.
- A frame's first beat is accepted no earlier than the cycle after the out handshake.
- in_valid held low stalls cnt indefinitely; there is no timeout.

## Test plan
- Quantization (FEAT_W=16, OFFSET=0, SHIFT=12, QBITS=2): samples 0x1000, 0xFFFB (−5), 0x7FFF, 0x2FFF → q = 1, 0, 3, 2. The packed field for features 0..3 reads bits[7:0] = 8'b10_11_00_01.
- Full frame, continuous in_valid, out_ready = 1: 16 beats with in_last on beat 15 → out_valid high exactly one cycle after beat 15. in_ready is low that cycle and high the next.
- Backpressure: out_ready held 0 for 10 cycles → out_valid and out_data stable and in_ready = 0 throughout. Handshake on cycle 11, then COLLECT resumes.
- Short frame: in_last on beat 5 → no out_valid, err pulses once, err_cnt = 1. The next well-formed frame emits normally.
- Long frame: 20 beats with in_last on beat 19 → err on the beat-15 cycle, beats 16–19 accepted and discarded, no out_valid. The following frame is correct.
- Reset during beat 8 of a frame and again during HOLD → out_valid = 0 and out_data = 0 immediately, err_cnt = 0. A subsequent full frame emits with no remnants of the old data.

Source files
------------

// File: rtl/layer0_input_quantizer_if.sv
// Stream bundle between the sample source, the quantizer and the layer-0 input register.
// Handshakes: a beat or frame moves on a rising edge where valid && ready are both high.
// The source holds a beat stable until it is taken.
interface layer0_input_quantizer_if #(
  parameter int FEAT_W = 16,
  parameter int N_FEAT = 16,
  parameter int QBITS  = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [FEAT_W-1:0]         in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_FEAT*QBITS-1:0]   out_data;
  logic                      err;
  logic [15:0]               err_cnt;
  logic [1:0]                state_dbg;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, err, err_cnt, state_dbg
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, err, err_cnt, state_dbg
  );
endinterface

// File: rtl/layer0_input_quantizer.sv
// Quantizes a serial frame of signed features to QBITS each, packs them for the layer-0 LUTs,
// and drops short or long frames while counting them.
module layer0_input_quantizer #(
  parameter int                       FEAT_W = 16,
  parameter int                       N_FEAT = 16,
  parameter int                       QBITS  = 2,
  parameter logic signed [FEAT_W-1:0] OFFSET = '0,
  parameter int                       SHIFT  = 12
) (
  input logic clk,
  input logic rst,
  layer0_input_quantizer_if.slave bus
);
  localparam int CNT_W = $clog2(N_FEAT);
  localparam int OUT_W = N_FEAT * QBITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  shadow_q, shadow_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              err_q, err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic signed [FEAT_W:0] diff;
  logic signed [FEAT_W:0] shifted;
  logic [QBITS-1:0]       q;
  logic                   in_ready;
  logic                   accept;

  // One extra bit keeps the offset subtraction from wrapping.
  assign diff    = $signed({bus.in_data[FEAT_W-1], bus.in_data}) - $signed({OFFSET[FEAT_W-1], OFFSET});
  assign shifted = diff >>> SHIFT;

  always_comb begin
    q = shifted[QBITS-1:0];
    if (shifted[FEAT_W]) begin
      q = '0;
    end else if (|shifted[FEAT_W-1:QBITS]) begin
      q = '1;
    end
  end

  assign in_ready = !rst && (state_q != HOLD);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    out_data_d = out_data_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q != LAST_IDX) begin
            if (bus.in_last) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              shadow_d[int'(cnt_q)*QBITS +: QBITS] = q;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
            if (bus.in_last) begin
              out_data_d = shadow_q;
              out_data_d[(N_FEAT-1)*QBITS +: QBITS] = q;
              state_d = HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = COLLECT;
      end
      DRAIN: begin
        if (accept && bus.in_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      shadow_q   <= '0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      out_data_q <= out_data_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_layer0_input_quantizer.sv
// Bench for layer0_input_quantizer: table-driven quantization frame, directed framing and
// reset sequences, and randomized frames against an arithmetic reference model.
module tb_layer0_input_quantizer;
  localparam int FEAT_W = 16;
  localparam int N_FEAT = 16;
  localparam int QBITS  = 2;
  localparam int OFFSET = 0;
  localparam int SHIFT  = 12;
  localparam int OUT_W  = N_FEAT * QBITS;

  typedef struct {
    logic [FEAT_W-1:0] sample;
    logic [QBITS-1:0]  q_exp;
  } vec_t;

  logic clk;
  logic rst;

  layer0_input_quantizer_if #(.FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .QBITS(QBITS)) bus ();

  layer0_input_quantizer #(
    .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .QBITS(QBITS),
    .OFFSET(16'(OFFSET)), .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] last_out;
  logic [15:0]      err_cnt_m;
  vec_t             tab[N_FEAT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain integer arithmetic with clamping
  function automatic int quant(input logic [FEAT_W-1:0] x);
    int d;
    int s;
    d = int'($signed(x)) - OFFSET;
    s = d >>> SHIFT;
    if (s < 0) return 0;
    if (s > (1 << QBITS) - 1) return (1 << QBITS) - 1;
    return s;
  endfunction

  // driver: presents one beat, waits for acceptance, returns #1 after the accepting edge
  task automatic send_beat(input logic [FEAT_W-1:0] d, input logic last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("beat_accept_timeout", 64'(t >= 50), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // wait_c < 0 leaves the frame pending in HOLD
  task automatic send_frame(input int len, input int wait_c, input bit use_tab);
    logic [OUT_W-1:0]  exp_pack;
    logic [FEAT_W-1:0] smp;
    logic              exp_err;
    logic              exp_ov;
    exp_pack = '0;
    for (int k = 0; k < len; k++) begin
      smp = use_tab ? tab[k % N_FEAT].sample : FEAT_W'($urandom);
      if (k < N_FEAT) exp_pack[k*QBITS +: QBITS] = QBITS'(quant(smp));
      exp_err = ((len < N_FEAT) && (k == len - 1)) || ((len > N_FEAT) && (k == N_FEAT - 1));
      exp_ov  = (len == N_FEAT) && (k == N_FEAT - 1);
      if (exp_err && err_cnt_m != 16'hFFFF) err_cnt_m++;
      send_beat(smp, 1'(k == len - 1));
      check("err_pulse", 64'(bus.err), 64'(exp_err));
      check("out_valid_beat", 64'(bus.out_valid), 64'(exp_ov));
      check("err_cnt_beat", 64'(bus.err_cnt), 64'(err_cnt_m));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (len == N_FEAT) begin
      exp_q.push_back(exp_pack);
      check("in_ready_hold", 64'(bus.in_ready), 64'd0);
      check("out_data_frame", 64'(bus.out_data), 64'(exp_q[0]));
      if (wait_c >= 0) begin
        for (int c = 0; c < wait_c; c++) begin
          @(posedge clk);
          #1;
          check("bp_out_valid", 64'(bus.out_valid), 64'd1);
          check("bp_out_data", 64'(bus.out_data), 64'(exp_q[0]));
          check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        last_out = exp_q.pop_front();
        check("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_hs_out_data_kept", 64'(bus.out_data), 64'(last_out));
      end
    end else begin
      @(posedge clk);
      #1;
      check("drop_err_low", 64'(bus.err), 64'd0);
      check("drop_no_out_valid", 64'(bus.out_valid), 64'd0);
      check("drop_out_data_kept", 64'(bus.out_data), 64'(last_out));
      check("drop_err_cnt", 64'(bus.err_cnt), 64'(err_cnt_m));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    err_cnt_m = '0;
    last_out  = '0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_err_low", 64'(bus.err), 64'd0);
  endtask

  initial begin
    logic [7:0] low8;
    int len;
    int r;
    tab = '{
      '{16'h1000, 2'd1}, '{16'hFFFB, 2'd0}, '{16'h7FFF, 2'd3}, '{16'h2FFF, 2'd2},
      '{16'h0000, 2'd0}, '{16'h0FFF, 2'd0}, '{16'h2000, 2'd2}, '{16'h3FFF, 2'd3},
      '{16'h4000, 2'd3}, '{16'h8000, 2'd0}, '{16'hF000, 2'd0}, '{16'h1FFF, 2'd1},
      '{16'h3000, 2'd3}, '{16'h0001, 2'd0}, '{16'h2001, 2'd2}, '{16'h1001, 2'd1}
    };
    err_cnt_m     = '0;
    last_out      = '0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_data", 64'(bus.out_data), 64'd0);
    check("reset_err", 64'(bus.err), 64'd0);
    check("reset_err_cnt", 64'(bus.err_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);

    // table-driven quantization frame, out_ready given right after out_valid rises
    send_frame(N_FEAT, 0, 1'b1);
    for (int i = 0; i < N_FEAT; i++) begin
      check($sformatf("tab_q%0d", i), 64'(bus.out_data[i*QBITS +: QBITS]), 64'(tab[i].q_exp));
      check($sformatf("tab_model%0d", i), 64'(quant(tab[i].sample)), 64'(tab[i].q_exp));
    end
    low8 = bus.out_data[7:0];
    check("tab_low_byte", 64'(low8), 64'(8'b10_11_00_01));

    // backpressure, short frame, long frame, each followed by a good frame
    send_frame(N_FEAT, 10, 1'b0);
    send_frame(6, 0, 1'b0);
    check("short_err_cnt", 64'(bus.err_cnt), 64'd1);
    send_frame(N_FEAT, 0, 1'b0);
    send_frame(20, 0, 1'b0);
    check("long_err_cnt", 64'(bus.err_cnt), 64'd2);
    send_frame(N_FEAT, 1, 1'b0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      len = N_FEAT;
      else if (r < 8) len = $urandom_range(1, N_FEAT - 1);
      else            len = $urandom_range(N_FEAT + 1, N_FEAT + 6);
      send_frame(len, $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // reset during beat 8 of a frame
    for (int k = 0; k < 8; k++) send_beat(FEAT_W'($urandom), 1'b0);
    bus.in_data = 16'h7FFF;
    pulse_reset();
    send_frame(N_FEAT, 0, 1'b0);

    // reset while a frame is held
    send_frame(N_FEAT, -1, 1'b0);
    pulse_reset();
    send_frame(N_FEAT, 2, 1'b0);
    check("final_err_cnt", 64'(bus.err_cnt), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
